// File: rtl/bridge_rr_arb_ctrl.sv
// bridge_rr_arb_ctrl
// Round-robin arbitration controller for an N-master to 1-target bridge port
// of the L2/TCDM interconnect. One requester is picked per cycle and drives
// the datapath mux select. Every granted master index is pushed into an
// in-order tracking FIFO. The target response is routed back to the master
// at the FIFO head, so responses need no ID. The number of in-flight
// transactions is capped at MAX_OUTSTANDING.
//
// Ports
//   clk            clock
//   rst            synchronous reset, active-high
//   req_i          per-master request
//   gnt_o          per-master grant (one-hot or zero)
//   sel_o          datapath mux select (winner index, 0 when idle)
//   tgt_req_o      request to target
//   tgt_gnt_i      target grant
//   tgt_r_valid_i  target response valid, in request order
//   r_valid_o      per-master response valid (one-hot or zero)
//   outstanding_o  in-flight request count
//   full_o         outstanding_o == MAX_OUTSTANDING
//   err_o          one-cycle pulse: response received with nothing in flight
module bridge_rr_arb_ctrl #(
    parameter int N_MASTER        = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SEL_WIDTH       = $clog2(N_MASTER),
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTER-1:0]  req_i,
    output logic [N_MASTER-1:0]  gnt_o,
    output logic [SEL_WIDTH-1:0] sel_o,
    output logic                 tgt_req_o,
    input  logic                 tgt_gnt_i,
    input  logic                 tgt_r_valid_i,
    output logic [N_MASTER-1:0]  r_valid_o,
    output logic [CNT_WIDTH-1:0] outstanding_o,
    output logic                 full_o,
    output logic                 err_o
);

    // A depth of one still needs a one-bit pointer to keep the vectors legal.
    localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [SEL_WIDTH-1:0] ptr;
    logic [SEL_WIDTH-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic                 err_q;

    logic [SEL_WIDTH-1:0] winner;
    logic                 hs;
    logic                 pop;
    logic                 empty;
    logic [SEL_WIDTH-1:0] fifo_head;
    int                   scan_idx;
    logic                 found;

    // Rotating priority scan starting at ptr. The index is reduced modulo
    // N_MASTER by a single subtraction, which keeps non-power-of-2 master
    // counts correct without a divider.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < N_MASTER; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= N_MASTER) begin
                scan_idx = scan_idx - N_MASTER;
            end
            if (!found && req_i[scan_idx]) begin
                found  = 1'b1;
                winner = SEL_WIDTH'(scan_idx);
            end
        end
    end

    // Full blocks new requests even when a pop happens in the same cycle,
    // so the request path never depends on the response input.
    assign empty     = (count == '0);
    assign full_o    = (count == CNT_WIDTH'(MAX_OUTSTANDING));
    assign tgt_req_o = (|req_i) & ~full_o;
    assign hs        = tgt_req_o & tgt_gnt_i;
    assign sel_o     = winner;
    assign gnt_o     = hs ? ({{(N_MASTER-1){1'b0}}, 1'b1} << winner) : '0;

    // Responses come back in request order, so the FIFO head names the
    // master that owns the current response.
    assign fifo_head     = fifo_mem[rd_ptr];
    assign pop           = tgt_r_valid_i & ~empty;
    assign r_valid_o     = pop ? ({{(N_MASTER-1){1'b0}}, 1'b1} << fifo_head) : '0;
    assign outstanding_o = count;
    assign err_o         = err_q;

    // Arbitration pointer, tracking FIFO and occupancy counter. The FIFO
    // storage itself is not reset: reset empties it through the pointers and
    // the count, which discards any in-flight entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= tgt_r_valid_i & empty;

            if (hs) begin
                ptr              <= (winner == SEL_WIDTH'(N_MASTER - 1)) ? '0
                                                                         : winner + SEL_WIDTH'(1);
                fifo_mem[wr_ptr] <= winner;
                wr_ptr           <= (wr_ptr == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0
                                                                               : wr_ptr + PTR_WIDTH'(1);
            end

            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0
                                                                       : rd_ptr + PTR_WIDTH'(1);
            end

            case ({hs, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
